// File: rtl/zeroriscy_mem_arbiter.sv
// zeroriscy_mem_arbiter: shares one memory port between fetch and LSU, with owner lock and in-order response routing.
// Define ZERORISCY_ARB_ROUND_ROBIN_EN for alternating arbitration; otherwise data has fixed priority.
module zeroriscy_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {ARB_FREE, ARB_LOCK_I, ARB_LOCK_D} arb_state_e;

    arb_state_e                 state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic                       sel_data, full, push, pop, prefer_data;

`ifdef ZERORISCY_ARB_ROUND_ROBIN_EN
    logic rr_q, rr_d;
    assign prefer_data = rr_q;
`else
    assign prefer_data = 1'b1;
`endif

    always_comb begin
        sel_data = state_q == ARB_LOCK_D ? 1'b1 :
                   state_q == ARB_LOCK_I ? 1'b0 :
                   data_req_i & (~instr_req_i | prefer_data);
        full     = cnt_q == CW'(MAX_OUTSTANDING);
        mem_req_o = ~rst & ~full & (sel_data ? data_req_i : instr_req_i);
        push     = mem_req_o & mem_gnt_i;
        pop      = mem_rvalid_i & (cnt_q != '0);
        state_d  = push      ? ARB_FREE :
                   mem_req_o ? (sel_data ? ARB_LOCK_D : ARB_LOCK_I) : state_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        // FIFO head sits at bit 0; a pop shifts before the new owner lands behind the survivors
        fifo_d   = pop ? fifo_q >> 1 : fifo_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++)
            if (push && i == int'(cnt_q) - int'(pop)) fifo_d[i] = sel_data;
`ifdef ZERORISCY_ARB_ROUND_ROBIN_EN
        rr_d     = push ? ~sel_data : rr_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_FREE;
            cnt_q   <= '0;
            fifo_q  <= '0;
`ifdef ZERORISCY_ARB_ROUND_ROBIN_EN
            rr_q    <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fifo_q  <= fifo_d;
`ifdef ZERORISCY_ARB_ROUND_ROBIN_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign mem_addr_o     = rst ? '0 : (sel_data ? data_addr_i : instr_addr_i);
    assign mem_we_o       = ~rst & sel_data & data_we_i;
    assign mem_be_o       = rst ? '0 : (sel_data ? data_be_i : 4'hf);
    assign mem_wdata_o    = rst | ~sel_data ? '0 : data_wdata_i;
    assign instr_gnt_o    = push & ~sel_data;
    assign data_gnt_o     = push & sel_data;
    assign instr_rvalid_o = pop & ~fifo_q[0];
    assign data_rvalid_o  = pop & fifo_q[0];
    assign instr_rdata_o  = rst ? '0 : mem_rdata_i;
    assign data_rdata_o   = rst ? '0 : mem_rdata_i;
    assign busy_o         = ~rst & ((cnt_q != '0) | mem_req_o);

`ifndef SYNTHESIS
    lock_i_held_a: assert property (@(posedge clk) disable iff (rst) state_q == ARB_LOCK_I |-> instr_req_i);
    lock_d_held_a: assert property (@(posedge clk) disable iff (rst) state_q == ARB_LOCK_D |-> data_req_i);
`endif
endmodule

// File: doc/zeroriscy_mem_arbiter.md
ZERORISCY_MEM_ARBITER -- requirements
Module: zeroriscy_mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_OUTSTANDING, default 2, max granted-but-unanswered memory transactions (legal 1..4).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have ports instr_req_i (in, 1), instr_addr_i (in, 32), instr_gnt_o (out, 1), instr_rvalid_o (out, 1), instr_rdata_o (out, 32), the fetch-side request/grant/rvalid port.
REQ-005 The block SHALL have ports data_req_i (in, 1), data_addr_i (in, 32), data_we_i (in, 1), data_be_i (in, 4), data_wdata_i (in, 32), data_gnt_o (out, 1), data_rvalid_o (out, 1), data_rdata_o (out, 32), the LSU-side port.
REQ-006 The block SHALL have ports mem_req_o (out, 1), mem_addr_o (out, 32), mem_we_o (out, 1), mem_be_o (out, 4), mem_wdata_o (out, 32), mem_gnt_i (in, 1), mem_rvalid_i (in, 1), mem_rdata_i (in, 32), the shared memory port.
REQ-007 The block SHALL have port busy_o, output, 1, high while any request is pending or any transaction is outstanding.

Function
REQ-008 The block SHALL keep an owner FSM with states ARB_FREE, ARB_LOCK_I and ARB_LOCK_D.
REQ-009 In ARB_FREE, the winner SHALL be selected combinationally from the current requests, with zero-cycle latency from req to mem_req_o.
REQ-010 The FSM SHALL enter ARB_LOCK_I or ARB_LOCK_D when mem_req_o=1 and mem_gnt_i=0.
- While locked, the owner is fixed and mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o come from that owner only.
- The FSM returns to ARB_FREE in the cycle after mem_gnt_i=1.
REQ-011 For instruction fetches, mem_we_o SHALL be 0, mem_be_o SHALL be 4'b1111, and mem_wdata_o SHALL be 0.
REQ-012 Grant routing SHALL be instr_gnt_o = mem_req_o & mem_gnt_i & (owner==instr), and data_gnt_o likewise for data; at most one grant is high per cycle.
REQ-013 The block SHALL keep an owner FIFO of depth MAX_OUTSTANDING with a count of width clog2(MAX_OUTSTANDING+1).
- Push the owner bit on mem_req_o & mem_gnt_i.
- Pop on mem_rvalid_i.
- Simultaneous push and pop leaves count unchanged and preserves order.
REQ-014 When count==MAX_OUTSTANDING, mem_req_o SHALL be 0 even if a pop occurs in the same cycle, and no grant is forwarded.
REQ-015 mem_rvalid_i SHALL drive the rvalid of the owner at the FIFO head only, in the same cycle.
- instr_rdata_o and data_rdata_o both equal mem_rdata_i.
REQ-016 mem_rvalid_i with an empty FIFO SHALL be ignored: no rvalid out, count stays 0.
REQ-017 A requester SHALL NOT be required to hold its request after its grant; the FSM must not stall on a dropped non-granted request when unlocked.
REQ-018 Requests dropped while locked SHALL be a protocol violation, flagged by a simulation-only assertion.
REQ-019 busy_o SHALL equal (count!=0) | mem_req_o.

Reset
REQ-020 While rst=1, the block SHALL hold FSM=ARB_FREE, FIFO empty and count=0, and the round-robin pointer at data.
REQ-021 While rst=1, every output SHALL be 0: mem_req_o, both gnt, both rvalid, busy_o, and all data/address outputs.
REQ-022 Reset asserted mid-transaction SHALL discard outstanding entries, and any rvalid arriving after release SHALL be ignored per REQ-016.

Configuration
REQ-023 With macro ZERORISCY_ARB_ROUND_ROBIN_EN defined, simultaneous requests in ARB_FREE SHALL be granted alternately.
- A 1-bit pointer toggles to the non-granted side on each accepted transfer.
- A single requester always wins.
REQ-024 Without ZERORISCY_ARB_ROUND_ROBIN_EN, data SHALL always have fixed priority over instr, and the pointer register SHALL not exist.

Verification
REQ-025 Instr-only: instr_req_i=1, addr 0x80, gnt same cycle, rvalid next cycle with 0x00000013 -> instr_gnt_o=1 in cycle 0, instr_rvalid_o=1 with rdata 0x13 in cycle 1, data_rvalid_o=0.
REQ-026 Lock: data request to 0x100 with gnt low for 3 cycles while instr_req_i rises in cycle 1 -> mem_addr_o stays 0x100 for all 4 cycles, data_gnt_o in cycle 3, instr issued in cycle 4.
REQ-027 Order: grant instr 0x0 then data 0x200 back-to-back, rvalids return two cycles later -> first rvalid goes to instr_rvalid_o, second to data_rvalid_o, count returns to 0.
REQ-028 Full: MAX_OUTSTANDING=2, two grants with no rvalid, then a third request -> mem_req_o=0 until the first rvalid; the third is issued the cycle after.
REQ-029 Both requesters held high for 4 grants: with macro, grants are D,I,D,I; without macro, D,D,D,D.
REQ-030 rst pulsed with 2 outstanding, then a stray rvalid -> no rvalid output, busy_o=0.
